expr_char_gen: RTL and testbench

Synthesizable ASCII expression-stream transmitter, the producer end of the expression recognizer's character interface. It emits one 8-bit character per cycle forming "d op d op ... d" (digits '0'-'9', operators '+'/'*'), pseudo-randomly drawn from an LFSR. It optionally corrupts one character. Alongside each character it drives `expect`, the recognizer output that character should produce, so the pair self-checks on-chip or in a bench.

---
 rtl/expr_char_gen.sv | 159 +++++++++++++++
 tb/tb_expr_char_gen.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/expr_char_gen.sv
// LFSR-driven producer of "d op d ... d" ASCII expression streams, with an
// optional single-character corruption and the matching recognizer verdict.
module expr_char_gen #(
  parameter int unsigned MAX_TERMS = 8,
  parameter logic [15:0] POLY      = 16'hB400
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic [15:0] seed,
  input  logic [3:0] terms,
  input  logic       err_en,
  input  logic [4:0] err_pos,
  output logic [7:0] char,
  output logic       char_valid,
  output logic       expect_flag,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIGIT = 2'd1,
    OP    = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_STAR = 8'h2A;
  localparam logic [15:0] SEED_SUB = 16'hACE1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    if (v[0]) begin
      return (v >> 1) ^ POLY;
    end else begin
      return v >> 1;
    end
  endfunction

  function automatic logic [3:0] clamp_terms(input logic [3:0] t);
    if (t == 4'd0) begin
      return 4'd1;
    end else if (32'(t) > MAX_TERMS) begin
      return 4'(MAX_TERMS);
    end else begin
      return t;
    end
  endfunction

  state_t      state_r, state_n;
  logic [15:0] lfsr_r, lfsr_n;
  logic [4:0]  idx_r, idx_n;
  logic [3:0]  n_r, n_n;
  logic        err_en_r, err_en_n;
  logic [4:0]  err_pos_r, err_pos_n;
  logic        sticky_r, sticky_n;

  logic [7:0]  char_n;
  logic        valid_n, expect_n, busy_n, done_n;

  logic [4:0]  last_idx;
  logic        corrupt;
  logic [3:0]  digit;

  assign last_idx = {n_r, 1'b0} - 5'd2;
  assign corrupt  = err_en_r && (idx_r == err_pos_r);
  assign digit    = (lfsr_r[3:0] >= 4'd10) ? (lfsr_r[3:0] - 4'd10) : lfsr_r[3:0];

  // Next-state, datapath and next-output decode.
  always_comb begin
    state_n   = state_r;
    lfsr_n    = lfsr_r;
    idx_n     = idx_r;
    n_n       = n_r;
    err_en_n  = err_en_r;
    err_pos_n = err_pos_r;
    sticky_n  = sticky_r;
    char_n    = 8'h00;
    valid_n   = 1'b0;
    expect_n  = 1'b0;
    busy_n    = 1'b0;
    done_n    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          lfsr_n    = (seed == 16'h0000) ? SEED_SUB : seed;
          n_n       = clamp_terms(terms);
          err_en_n  = err_en;
          err_pos_n = err_pos;
          idx_n     = 5'd0;
          sticky_n  = 1'b0;
          state_n   = DIGIT;
        end else begin
          state_n = IDLE;
        end
      end
      DIGIT: begin
        valid_n  = 1'b1;
        busy_n   = 1'b1;
        char_n   = corrupt ? CH_PLUS : (CH_ZERO + {4'd0, digit});
        expect_n = !corrupt && !sticky_r;
        sticky_n = sticky_r | corrupt;
        lfsr_n   = lfsr_step(lfsr_r);
        idx_n    = idx_r + 5'd1;
        state_n  = (idx_r == last_idx) ? DONE : OP;
      end
      OP: begin
        valid_n  = 1'b1;
        busy_n   = 1'b1;
        char_n   = corrupt ? CH_ZERO : (lfsr_r[0] ? CH_STAR : CH_PLUS);
        sticky_n = sticky_r | corrupt;
        lfsr_n   = lfsr_step(lfsr_r);
        idx_n    = idx_r + 5'd1;
        state_n  = DIGIT;
      end
      DONE: begin
        busy_n  = 1'b1;
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; clr abandons any stream at once.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r     <= IDLE;
      lfsr_r      <= 16'h0000;
      idx_r       <= 5'd0;
      n_r         <= 4'd1;
      err_en_r    <= 1'b0;
      err_pos_r   <= 5'd0;
      sticky_r    <= 1'b0;
      char        <= 8'h00;
      char_valid  <= 1'b0;
      expect_flag <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_r     <= state_n;
      lfsr_r      <= lfsr_n;
      idx_r       <= idx_n;
      n_r         <= n_n;
      err_en_r    <= err_en_n;
      err_pos_r   <= err_pos_n;
      sticky_r    <= sticky_n;
      char        <= char_n;
      char_valid  <= valid_n;
      expect_flag <= expect_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

endmodule

// File: tb/tb_expr_char_gen.sv
// Directed bench for expr_char_gen: hand-derived character streams for the
// ACE1 seed, corruption, seed substitution, clamping, clr and restart cases.
module tb_expr_char_gen;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [15:0] seed;
  logic [3:0]  terms;
  logic        err_en;
  logic [4:0]  err_pos;
  logic [7:0]  char;
  logic        char_valid;
  logic        expect_flag;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  logic [7:0] cap_c [0:19];
  logic       cap_v [0:19];
  logic       cap_e [0:19];
  logic       cap_d [0:19];
  logic       cap_b [0:19];

  // "1+8+4*3" from seed ACE1, computed by hand from the Galois LFSR.
  logic [7:0] ref_c [0:6] = '{8'h31, 8'h2B, 8'h38, 8'h2B, 8'h34, 8'h2A, 8'h33};
  logic       ref_e [0:4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] err_c [0:4] = '{8'h31, 8'h2B, 8'h2B, 8'h2B, 8'h34};
  logic       err_e [0:4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  expr_char_gen dut (
    .clk(clk), .clr(clr), .start(start), .seed(seed), .terms(terms),
    .err_en(err_en), .err_pos(err_pos), .char(char), .char_valid(char_valid),
    .expect_flag(expect_flag), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      cap_c[i] = char;
      cap_v[i] = char_valid;
      cap_e[i] = expect_flag;
      cap_d[i] = done;
      cap_b[i] = busy;
    end
  endtask

  task automatic launch(input logic [15:0] s, input logic [3:0] n,
                        input logic ee, input logic [4:0] ep);
    seed = s; terms = n; err_en = ee; err_pos = ep; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; start = 1'b0; seed = 16'h0; terms = 4'd0; err_en = 1'b0; err_pos = 5'd0;
    #3;
    total++;
    if ({char, char_valid, expect_flag, busy, done} !== 12'h000) begin
      bad++; $display("FAIL reset_async got=%h want=000", {char, char_valid, expect_flag, busy, done});
    end
    tick();
    tick();
    total++;
    if ({char, char_valid, expect_flag, busy, done} !== 12'h000) begin
      bad++; $display("FAIL reset_held got=%h want=000", {char, char_valid, expect_flag, busy, done});
    end
    clr = 1'b0;
    tick();
    total++;
    if ({char_valid, busy, done} !== 3'b000) begin
      bad++; $display("FAIL idle_after_reset got=%b want=000", {char_valid, busy, done});
    end
  endtask

  task automatic test_basic();
    launch(16'hACE1, 4'd3, 1'b0, 5'd0);
    capture(7);
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({cap_v[i], cap_c[i], cap_e[i], cap_b[i], cap_d[i]} !== {1'b1, ref_c[i], ref_e[i], 1'b1, 1'b0}) begin
        bad++; $display("FAIL basic_char%0d got v=%b c=%h e=%b b=%b d=%b want v=1 c=%h e=%b b=1 d=0",
                        i, cap_v[i], cap_c[i], cap_e[i], cap_b[i], cap_d[i], ref_c[i], ref_e[i]);
      end
    end
    total++;
    if ({cap_v[5], cap_c[5], cap_e[5], cap_b[5], cap_d[5]} !== {1'b0, 8'h00, 1'b0, 1'b1, 1'b1}) begin
      bad++; $display("FAIL basic_done got v=%b c=%h e=%b b=%b d=%b want v=0 c=00 e=0 b=1 d=1",
                      cap_v[5], cap_c[5], cap_e[5], cap_b[5], cap_d[5]);
    end
    total++;
    if ({cap_v[6], cap_b[6], cap_d[6]} !== 3'b000) begin
      bad++; $display("FAIL basic_after_done got v=%b b=%b d=%b want 000", cap_v[6], cap_b[6], cap_d[6]);
    end
  endtask

  task automatic test_error();
    launch(16'hACE1, 4'd3, 1'b1, 5'd2);
    capture(6);
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({cap_v[i], cap_c[i], cap_e[i]} !== {1'b1, err_c[i], err_e[i]}) begin
        bad++; $display("FAIL error_char%0d got v=%b c=%h e=%b want v=1 c=%h e=%b",
                        i, cap_v[i], cap_c[i], cap_e[i], err_c[i], err_e[i]);
      end
    end
    total++;
    if (cap_d[5] !== 1'b1) begin
      bad++; $display("FAIL error_done got=%b want=1", cap_d[5]);
    end
    tick();
  endtask

  task automatic test_seed_zero();
    for (int k = 0; k < 2; k++) begin
      launch(16'h0000, (k == 0) ? 4'd1 : 4'd0, 1'b0, 5'd0);
      capture(3);
      total++;
      if ({cap_v[0], cap_c[0], cap_e[0], cap_d[0]} !== {1'b1, 8'h31, 1'b1, 1'b0}) begin
        bad++; $display("FAIL seed0_n%0d_char got v=%b c=%h e=%b d=%b want v=1 c=31 e=1 d=0",
                        1 - k, cap_v[0], cap_c[0], cap_e[0], cap_d[0]);
      end
      total++;
      if ({cap_v[1], cap_d[1], cap_d[2], cap_b[2]} !== 4'b0100) begin
        bad++; $display("FAIL seed0_n%0d_done got v=%b d=%b d2=%b b2=%b want 0100",
                        1 - k, cap_v[1], cap_d[1], cap_d[2], cap_b[2]);
      end
    end
  endtask

  task automatic test_clamp();
    logic is_digit;
    logic is_op;
    launch(16'hACE1, 4'd15, 1'b1, 5'd20);
    capture(17);
    for (int i = 0; i < 15; i++) begin
      is_digit = (cap_c[i] >= 8'h30) && (cap_c[i] <= 8'h39);
      is_op    = (cap_c[i] == 8'h2B) || (cap_c[i] == 8'h2A);
      total++;
      if (i % 2 == 0) begin
        if ({cap_v[i], is_digit, cap_e[i]} !== 3'b111) begin
          bad++; $display("FAIL clamp_digit%0d got v=%b c=%h e=%b want digit with e=1", i, cap_v[i], cap_c[i], cap_e[i]);
        end
      end else begin
        if ({cap_v[i], is_op, cap_e[i]} !== 3'b110) begin
          bad++; $display("FAIL clamp_op%0d got v=%b c=%h e=%b want operator with e=0", i, cap_v[i], cap_c[i], cap_e[i]);
        end
      end
    end
    for (int i = 0; i < 7; i++) begin
      total++;
      if (cap_c[i] !== ref_c[i]) begin
        bad++; $display("FAIL clamp_prefix%0d got=%h want=%h", i, cap_c[i], ref_c[i]);
      end
    end
    total++;
    if ({cap_v[15], cap_d[15], cap_d[16], cap_b[16]} !== 4'b0100) begin
      bad++; $display("FAIL clamp_length got v15=%b d15=%b d16=%b b16=%b want 0100",
                      cap_v[15], cap_d[15], cap_d[16], cap_b[16]);
    end
  endtask

  task automatic test_clr_mid();
    launch(16'hACE1, 4'd3, 1'b0, 5'd0);
    tick();
    tick();
    tick();
    total++;
    if ({char_valid, char} !== {1'b1, 8'h38}) begin
      bad++; $display("FAIL clrmid_third got v=%b c=%h want v=1 c=38", char_valid, char);
    end
    #2;
    clr = 1'b1;
    #1;
    total++;
    if ({char, char_valid, expect_flag, busy, done} !== 12'h000) begin
      bad++; $display("FAIL clrmid_async got=%h want=000", {char, char_valid, expect_flag, busy, done});
    end
    tick();
    clr = 1'b0;
    capture(6);
    for (int i = 0; i < 6; i++) begin
      total++;
      if ({cap_v[i], cap_d[i], cap_b[i]} !== 3'b000) begin
        bad++; $display("FAIL clrmid_quiet%0d got v=%b d=%b b=%b want 000", i, cap_v[i], cap_d[i], cap_b[i]);
      end
    end
    launch(16'hACE1, 4'd3, 1'b0, 5'd0);
    capture(6);
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({cap_v[i], cap_c[i], cap_e[i]} !== {1'b1, ref_c[i], ref_e[i]}) begin
        bad++; $display("FAIL clrmid_restart%0d got v=%b c=%h e=%b want v=1 c=%h e=%b",
                        i, cap_v[i], cap_c[i], cap_e[i], ref_c[i], ref_e[i]);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    launch(16'hACE1, 4'd3, 1'b0, 5'd0);
    capture(2);
    seed = 16'h1234; terms = 4'd1; start = 1'b1;
    capture(1);
    start = 1'b0;
    cap_c[2] = char;
    capture(5);
    total++;
    if ({cap_c[0], cap_c[1], cap_c[2], cap_c[3]} !== {ref_c[3], ref_c[4], 8'h00, 8'h00}) begin
      bad++; $display("FAIL busy_start_ignored got %h %h %h %h want %h %h 00 00",
                      cap_c[0], cap_c[1], cap_c[2], cap_c[3], ref_c[3], ref_c[4]);
    end
    total++;
    if ({cap_d[2], cap_v[3], cap_v[4], cap_b[4]} !== 4'b1000) begin
      bad++; $display("FAIL busy_no_requeue got d=%b v3=%b v4=%b b4=%b want 1000",
                      cap_d[2], cap_v[3], cap_v[4], cap_b[4]);
    end
    seed = 16'hACE1; terms = 4'd3; err_en = 1'b0; start = 1'b1;
    tick();
    capture(12);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({cap_v[i], cap_c[i], cap_v[i + 7], cap_c[i + 7], cap_e[i + 7]} !==
          {1'b1, ref_c[i], 1'b1, ref_c[i], ref_e[i]}) begin
        bad++; $display("FAIL held_start%0d got first=%h second=%h v=%b%b e=%b want %h",
                        i, cap_c[i], cap_c[i + 7], cap_v[i], cap_v[i + 7], cap_e[i + 7], ref_c[i]);
      end
    end
    total++;
    if ({cap_v[5], cap_d[5], cap_v[6], cap_d[6], cap_b[6]} !== 5'b01000) begin
      bad++; $display("FAIL held_gap got v5=%b d5=%b v6=%b d6=%b b6=%b want 01000",
                      cap_v[5], cap_d[5], cap_v[6], cap_d[6], cap_b[6]);
    end
    capture(3);
    total++;
    if ({cap_d[0], cap_v[1], cap_b[1]} !== 3'b100) begin
      bad++; $display("FAIL held_end got d=%b v=%b b=%b want 100", cap_d[0], cap_v[1], cap_b[1]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_error();
    test_seed_zero();
    test_clamp();
    test_clr_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
